ram_sp_be: RTL and testbench

- Next-generation parametrised single-port inferred RAM with per-byte write enables.
- Selectable read-during-write mode, optional output register stage, and a read-valid strobe.
- Optional hardware clear of the whole array after reset, with a busy flag.
- Drop-in storage for packet buffers and register files where software-visible contents must start from a known value.

---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_sp_be_if.sv | 29 ++
 rtl/ram_clear_seq.sv | 57 +++++
 rtl/ram_sp_be.sv | 134 +++++++++++++
 tb/tb_ram_sp_be.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared constants and types for the byte-enable single-port RAM.
// Read-during-write mode codes and clear sequencer state encoding.
package ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RDW_NO_CHANGE   = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clr_state_t;

endpackage

// File: rtl/ram_sp_be_if.sv
// Request/response bundle for the byte-enable single-port RAM.
// The master issues reads and writes; the slave returns data, valid and busy.
interface ram_sp_be_if #(
    parameter int DATAWIDTH = 32,
    parameter int ADDRWIDTH = 9,
    parameter int BYTEWIDTH = 8
);
    localparam int NBYTES = DATAWIDTH / BYTEWIDTH;

    logic [ADDRWIDTH-1:0] addr;
    logic [DATAWIDTH-1:0] wr_data;
    logic                 we;
    logic [NBYTES-1:0]    be;
    logic                 re;
    logic [DATAWIDTH-1:0] rd_data;
    logic                 rd_valid;
    logic                 busy;

    modport master (
        output addr, wr_data, we, be, re,
        input  rd_data, rd_valid, busy
    );

    modport slave (
        input  addr, wr_data, we, be, re,
        output rd_data, rd_valid, busy
    );

endinterface

// File: rtl/ram_clear_seq.sv
// Post-reset clear sequencer: walks every word address once.
// Drives the write port while busy so the array starts from a known value.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int ADDRWIDTH      = 9,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 i_reset,
    output logic                 o_clr_we,
    output logic [ADDRWIDTH-1:0] o_clr_addr,
    output logic                 o_busy
);

    clr_state_t           r_state;
    clr_state_t           w_state_nxt;
    logic [ADDRWIDTH-1:0] r_cnt;
    logic [ADDRWIDTH-1:0] w_cnt_nxt;

    // State and counter registers; reset restarts the sweep at word 0
    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Advance one word per cycle; leave CLEAR after the last word
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == {ADDRWIDTH{1'b1}}) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                w_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Reset itself must never touch the array, so gate the write
    assign o_clr_we   = (r_state == CLEAR) && !i_reset;
    assign o_clr_addr = r_cnt;
    assign o_busy     = (r_state == CLEAR);

endmodule

// File: rtl/ram_sp_be.sv
// Single-port inferred RAM with per-byte write enables, selectable
// read-during-write behaviour, optional output register and clear sweep.
module ram_sp_be
    import ram_pkg::*;
#(
    parameter int                   DATAWIDTH      = 32,
    parameter int                   ADDRWIDTH      = 9,
    parameter int                   BYTEWIDTH      = 8,
    parameter int                   RDW_MODE       = 0,
    parameter int                   OUT_REG        = 0,
    parameter int                   CLEAR_ON_RESET = 1,
    parameter logic [DATAWIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic        clk,
    input  logic        reset,
    ram_sp_be_if.slave  bus
);

    localparam int NBYTES = DATAWIDTH / BYTEWIDTH;
    localparam int DEPTH  = 1 << ADDRWIDTH;

    if (DATAWIDTH % BYTEWIDTH != 0) begin : g_chk
        $fatal(1, "ram_sp_be: DATAWIDTH must be a multiple of BYTEWIDTH");
    end

    logic [DATAWIDTH-1:0] r_mem [0:DEPTH-1];

    logic                 w_clr_we;
    logic [ADDRWIDTH-1:0] w_clr_addr;
    logic                 w_busy;
    logic                 w_blk;
    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic                 w_wr_en;
    logic [ADDRWIDTH-1:0] w_wr_addr;
    logic [DATAWIDTH-1:0] w_wr_data;
    logic [NBYTES-1:0]    w_wr_be;
    logic [DATAWIDTH-1:0] w_old;
    logic [DATAWIDTH-1:0] w_merged;
    logic [DATAWIDTH-1:0] w_rd_word;
    logic                 r_v1;
    logic [DATAWIDTH-1:0] r_rd1;

    ram_clear_seq #(
        .ADDRWIDTH      (ADDRWIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clr (
        .clk        (clk),
        .i_reset    (reset),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_busy     (w_busy)
    );

    assign bus.busy = w_busy;

    // User traffic is dropped outright while clearing or in reset
    assign w_blk    = w_busy || reset;
    assign w_wr_acc = bus.we && !w_blk;
    assign w_rd_acc = bus.re && !w_blk &&
                      !((RDW_MODE == RDW_NO_CHANGE) && bus.we);

    // Write-port mux: the clear sweep owns the port while it runs
    always_comb begin
        w_wr_en   = w_clr_we || w_wr_acc;
        w_wr_addr = w_clr_we ? w_clr_addr : bus.addr;
        w_wr_data = w_clr_we ? CLEAR_VALUE : bus.wr_data;
        w_wr_be   = w_clr_we ? {NBYTES{1'b1}} : bus.be;
    end

    // Byte-lane write into the array; contents survive reset
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int k = 0; k < NBYTES; k++) begin
                if (w_wr_be[k]) begin
                    r_mem[w_wr_addr][k*BYTEWIDTH +: BYTEWIDTH] <=
                        w_wr_data[k*BYTEWIDTH +: BYTEWIDTH];
                end
            end
        end
    end

    assign w_old = r_mem[bus.addr];

    // Word as it will look after this cycle's write, for WRITE_FIRST
    always_comb begin
        w_merged = w_old;
        for (int k = 0; k < NBYTES; k++) begin
            if (bus.be[k]) begin
                w_merged[k*BYTEWIDTH +: BYTEWIDTH] =
                    bus.wr_data[k*BYTEWIDTH +: BYTEWIDTH];
            end
        end
    end

    assign w_rd_word = ((RDW_MODE == RDW_WRITE_FIRST) && w_wr_acc) ?
                       w_merged : w_old;

    // First read stage; data holds when no read is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1  <= 1'b0;
            r_rd1 <= '0;
        end else begin
            r_v1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd1 <= w_rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic                 r_v2;
        logic [DATAWIDTH-1:0] r_rd2;

        // Second stage tracks the first every cycle
        always_ff @(posedge clk) begin
            if (reset) begin
                r_v2  <= 1'b0;
                r_rd2 <= '0;
            end else begin
                r_v2  <= r_v1;
                r_rd2 <= r_rd1;
            end
        end

        assign bus.rd_valid = r_v2;
        assign bus.rd_data  = r_rd2;
    end else begin : g_noreg
        assign bus.rd_valid = r_v1;
        assign bus.rd_data  = r_rd1;
    end

endmodule

// File: tb/tb_ram_sp_be.sv
// Scoreboard bench: four RAM variants share one random stimulus stream,
// a word-array reference model predicts each read, a monitor checks outputs.
module tb_ram_sp_be;

    localparam logic [31:0] CV = 32'hA5A5A5A5;
    localparam int ND = 4;

    typedef struct {
        int          dut;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic        re = 1'b0;

    logic [ND-1:0][31:0] rdd;
    logic [ND-1:0]       rdv;
    logic [ND-1:0]       bsy;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int MODE = (g == 1) ? 1 : (g == 2) ? 2 : 0;
        localparam int OREG = (g == 3) ? 1 : 0;

        ram_sp_be_if #(
            .DATAWIDTH (32),
            .ADDRWIDTH (4),
            .BYTEWIDTH (8)
        ) u_if ();

        assign u_if.addr    = addr;
        assign u_if.wr_data = wr_data;
        assign u_if.we      = we;
        assign u_if.be      = be;
        assign u_if.re      = re;
        assign rdd[g]       = u_if.rd_data;
        assign rdv[g]       = u_if.rd_valid;
        assign bsy[g]       = u_if.busy;

        ram_sp_be #(
            .DATAWIDTH      (32),
            .ADDRWIDTH      (4),
            .BYTEWIDTH      (8),
            .RDW_MODE       (MODE),
            .OUT_REG        (OREG),
            .CLEAR_ON_RESET (1),
            .CLEAR_VALUE    (CV)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (u_if.slave)
        );
    end

    logic [31:0] mem [16];
    exp_t        q[$];
    int          mcyc = 0;
    int          epoch = 0;
    bit          m_busy = 1'b0;
    int          clr_idx = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // One clock edge: advance the reference model with this cycle's inputs
    task automatic tick();
        logic [31:0] old;
        logic [31:0] merged;
        int          n;
        @(posedge clk);
        mcyc++;
        n = mcyc;
        if (reset) begin
            m_busy  = 1'b1;
            clr_idx = 0;
            epoch++;
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i].due >= n) q.delete(i);
        end else if (m_busy) begin
            mem[clr_idx] = CV;
            clr_idx++;
            if (clr_idx == 16) m_busy = 1'b0;
        end else begin
            old = mem[addr];
            merged = old;
            for (int k = 0; k < 4; k++)
                if (be[k]) merged[k*8 +: 8] = wr_data[k*8 +: 8];
            if (re) begin
                q.push_back('{0, old, n});
                q.push_back('{1, we ? merged : old, n});
                if (!we) q.push_back('{2, old, n});
                q.push_back('{3, old, n + 1});
            end
            if (we) mem[addr] = merged;
        end
        #1;
    endtask

    task automatic drive(bit r, bit w, bit rd, logic [3:0] a,
                         logic [31:0] d, logic [3:0] b);
        reset = r; we = w; re = rd; addr = a; wr_data = d; be = b;
        tick();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 4'd0, 32'd0, 4'd0);
    endtask

    task automatic rand_in();
        reset   = 1'b0;
        we      = 1'($urandom);
        re      = 1'($urandom);
        addr    = 4'($urandom_range(15));
        wr_data = $urandom;
        be      = 4'($urandom_range(15));
    endtask

    // Ride out a clear with random traffic, counting busy cycles
    task automatic wait_idle(string tag);
        int cnt;
        cnt = 0;
        while (bsy[0] && cnt < 40) begin
            rand_in();
            tick();
            cnt++;
        end
        n_cmp++;
        if (cnt != 16) begin
            n_bad++;
            $display("FAIL %s busy_cycles got=%0d exp=16", tag, cnt);
        end
        idle(1);
    endtask

    int          mon_epoch [ND];
    logic [31:0] last [ND];

    // Monitor: pop expectations on rd_valid, otherwise check data hold
    always @(negedge clk) begin
        int idx;
        if (mcyc >= 1) begin
            for (int d = 0; d < ND; d++) begin
                if (mon_epoch[d] != epoch) begin
                    mon_epoch[d] = epoch;
                    last[d] = '0;
                end
                idx = -1;
                for (int i = 0; i < q.size(); i++)
                    if (q[i].dut == d) begin
                        idx = i;
                        break;
                    end
                n_cmp++;
                if (rdv[d] === 1'b1) begin
                    if (idx < 0) begin
                        n_bad++;
                        $display("FAIL d%0d unexpected_valid cyc=%0d data=%h",
                                 d, mcyc, rdd[d]);
                    end else begin
                        if (q[idx].due != mcyc || rdd[d] !== q[idx].data) begin
                            n_bad++;
                            $display("FAIL d%0d read cyc=%0d got=%h exp=%h due=%0d",
                                     d, mcyc, rdd[d], q[idx].data, q[idx].due);
                        end
                        last[d] = q[idx].data;
                        q.delete(idx);
                    end
                end else if (rdv[d] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL d%0d valid_x cyc=%0d got=%b exp=0/1",
                             d, mcyc, rdv[d]);
                end else if (idx >= 0 && q[idx].due == mcyc) begin
                    n_bad++;
                    $display("FAIL d%0d missing_valid cyc=%0d got=0 exp=1 data=%h",
                             d, mcyc, q[idx].data);
                    q.delete(idx);
                end else if (rdd[d] !== last[d]) begin
                    n_bad++;
                    $display("FAIL d%0d hold cyc=%0d got=%h exp=%h",
                             d, mcyc, rdd[d], last[d]);
                end
                n_cmp++;
                if (bsy[d] !== m_busy) begin
                    n_bad++;
                    $display("FAIL d%0d busy cyc=%0d got=%b exp=%b",
                             d, mcyc, bsy[d], m_busy);
                end
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < ND; d++) begin
            mon_epoch[d] = 0;
            last[d] = '0;
        end
        // Power-up clear, random traffic during busy is discarded
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 4'd0, 32'd0, 4'd0);
        wait_idle("init_clear");
        for (int a = 0; a < 16; a++) drive(0, 0, 1, 4'(a), 32'd0, 4'd0);
        idle(3);
        // Byte lanes
        drive(0, 1, 0, 4'd5, 32'h11223344, 4'hF);
        drive(0, 1, 0, 4'd5, 32'hAABBCCDD, 4'b0101);
        drive(0, 0, 1, 4'd5, 32'd0, 4'd0);
        idle(3);
        // Read-during-write on a zeroed word
        drive(0, 1, 0, 4'd3, 32'h0, 4'hF);
        drive(0, 1, 1, 4'd3, 32'hFFFFFFFF, 4'b0011);
        idle(2);
        drive(0, 0, 1, 4'd3, 32'd0, 4'd0);
        idle(3);
        // Back-to-back reads
        for (int a = 0; a < 4; a++) drive(0, 1, 0, 4'(a), 32'(10 + a), 4'hF);
        for (int a = 0; a < 4; a++) drive(0, 0, 1, 4'(a), 32'd0, 4'd0);
        idle(5);
        // Random traffic
        for (int i = 0; i < 300; i++) begin
            rand_in();
            tick();
        end
        idle(3);
        // Reads in flight when reset hits
        drive(0, 0, 1, 4'd1, 32'd0, 4'd0);
        drive(0, 0, 1, 4'd2, 32'd0, 4'd0);
        drive(1, 0, 1, 4'd3, 32'd0, 4'd0);
        wait_idle("inflight_reset");
        // Reset in the middle of a clear
        drive(0, 1, 0, 4'd15, 32'h12345678, 4'hF);
        drive(0, 0, 1, 4'd15, 32'd0, 4'd0);
        drive(1, 0, 0, 4'd0, 32'd0, 4'd0);
        for (int i = 0; i < 7; i++) begin
            rand_in();
            tick();
        end
        drive(1, 0, 0, 4'd0, 32'd0, 4'd0);
        wait_idle("mid_clear");
        for (int a = 15; a >= 0; a--) drive(0, 0, 1, 4'(a), 32'd0, 4'd0);
        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
